shift_arbiter: RTL and testbench

- Shares one 16-bit shift unit between two requesters (port 0, port 1) through round-robin arbitration.
- Each port has a valid/ready request channel and a valid/ready response channel.
- The block captures the winner's operands, performs the shift in a registered stage, and returns the result to the owning port only.
- It sits between the two issuing datapath blocks (e.g. ALU sequencer and address generator) and the shift resource.

---
 rtl/shift_arbiter.sv | 126 ++++++++++++
 tb/tb_shift_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered barrel shifter between two requesters.
// Each transaction takes IDLE (accept) -> SHIFT (compute) -> RESP (hold until taken).
module shift_arbiter #(
  parameter int DW         = 16,
  parameter int SW         = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [SW-1:0] req_amt0,
  input  logic [SW-1:0] req_amt1,
  input  logic [1:0]    req_dir,
  input  logic [1:0]    req_arith,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  localparam logic RP = 1'(RESET_PRIO);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          grant_q, grant_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] amt_q, amt_d;
  logic          dir_q, dir_d;
  logic          arith_q, arith_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          win;
  logic [DW-1:0] shift_res;

  // Barrel shift on the captured operands; requester inputs are no longer looked at.
  always_comb begin
    if (dir_q) begin
      shift_res = data_q << amt_q;
    end else if (arith_q) begin
      shift_res = DW'($signed(data_q) >>> amt_q);
    end else begin
      shift_res = data_q >> amt_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    grant_d    = grant_q;
    data_d     = data_q;
    amt_d      = amt_q;
    dir_d      = dir_q;
    arith_d    = arith_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    if (req_valid == 2'b01) begin
      win = 1'b0;
    end else if (req_valid == 2'b10) begin
      win = 1'b1;
    end else begin
      win = prio_q;
    end

    case (state_q)
      IDLE: begin
        // ready is masked while rst_n is low so outputs show reset values during reset
        if ((|req_valid) && rst_n) begin
          req_ready = 2'b01 << win;
          grant_d   = win;
          data_d    = win ? req_data1 : req_data0;
          amt_d     = win ? req_amt1 : req_amt0;
          dir_d     = req_dir[win];
          arith_d   = req_arith[win];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        rsp_data_d = shift_res;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 2'b01 << grant_q;
        if (rsp_ready[grant_q]) begin
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= RP;
      grant_q    <= RP;
      data_q     <= '0;
      amt_q      <= '0;
      dir_q      <= 1'b0;
      arith_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      amt_q      <= amt_d;
      dir_q      <= dir_d;
      arith_q    <= arith_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, reset corner cases,
// and random transactions checked against a bit-level reference model.
module tb_shift_arbiter;

  localparam int DW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_dir, req_arith;
  logic [1:0]    rsp_valid, rsp_ready;
  logic [DW-1:0] req_data0, req_data1, rsp_data;
  logic [SW-1:0] req_amt0, req_amt1;
  logic          busy, grant_id;

  int   total = 0;
  int   bad   = 0;
  logic prio_m;

  shift_arbiter #(.DW(DW), .SW(SW), .RESET_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_dir(req_dir), .req_arith(req_arith),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d0, d1;
    logic [3:0]  a0, a1;
    logic [1:0]  dir, arith;
    int          bp;
    logic        exp_w;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Each result bit is picked from its source position; out-of-range sources give the fill.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int n,
                                            input logic left, input logic arith);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      if (left) r[i] = (i >= n) ? d[i-n] : 1'b0;
      else      r[i] = (i + n < 16) ? d[i+n] : (arith & d[15]);
    end
    return r;
  endfunction

  function automatic logic model_winner(input logic [1:0] v);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return prio_m;
  endfunction

  task automatic run_txn(input string tag, input logic [1:0] v,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [1:0] dir, input logic [1:0] arith,
                         input int bp, input logic exp_w, input logic [15:0] exp_d);
    logic [1:0] own;
    own = 2'b01 << exp_w;
    req_valid = v; req_data0 = d0; req_data1 = d1; req_amt0 = a0; req_amt1 = a1;
    req_dir = dir; req_arith = arith; rsp_ready = 2'b00;
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'(own));
    @(posedge clk); #1;
    // operands change after acceptance must not leak into the result
    req_data0 = 16'($urandom); req_data1 = 16'($urandom);
    req_amt0 = 4'($urandom); req_amt1 = 4'($urandom);
    req_dir = 2'($urandom); req_arith = 2'($urandom);
    req_valid = v | 2'($urandom);
    @(negedge clk);
    chk({tag, ".shift_busy"}, 32'(busy), 32'd1);
    chk({tag, ".shift_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".shift_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".grant"}, 32'(grant_id), 32'(exp_w));
    @(posedge clk); #1;
    for (int c = 0; c < bp; c++) begin
      rsp_ready = ~own;
      req_valid = 2'($urandom);
      @(negedge clk);
      chk({tag, ".bp_rspv"}, 32'(rsp_valid), 32'(own));
      chk({tag, ".bp_data"}, 32'(rsp_data), 32'(exp_d));
      chk({tag, ".bp_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".bp_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = own | (~own & 2'($urandom));
    @(negedge clk);
    chk({tag, ".rspv"}, 32'(rsp_valid), 32'(own));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, ".rsp_grant"}, 32'(grant_id), 32'(exp_w));
    @(posedge clk); #1;
    prio_m = ~exp_w;
    rsp_ready = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".data"}, 32'(rsp_data), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".grant"}, 32'(grant_id), 32'd0);
  endtask

  task automatic release_and_serve_port1(input string tag);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prio_m = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk({tag, ".no_rsp"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_txn({tag, ".p1"}, 2'b10, 16'h0, 16'h00FF, 4'd0, 4'd4, 2'b10, 2'b00, 0,
            1'b1, 16'h0FF0);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 2'b11; req_data0 = '0; req_data1 = '0; req_amt0 = '0; req_amt1 = '0;
    req_dir = '0; req_arith = '0; rsp_ready = '0;
    prio_m = 1'b0;

    //           v      d0       d1       a0  a1  dir    arith  bp w  exp
    vecs[0]  = '{2'b11, 16'h1234, 16'h8000, 4,  1, 2'b01, 2'b10, 0, 0, 16'h2340};
    vecs[1]  = '{2'b11, 16'h1234, 16'h8000, 4,  1, 2'b01, 2'b10, 1, 1, 16'hC000};
    vecs[2]  = '{2'b11, 16'hFFFF, 16'h00F0, 8,  4, 2'b00, 2'b10, 0, 0, 16'h00FF};
    vecs[3]  = '{2'b11, 16'hFFFF, 16'h00F0, 8,  4, 2'b00, 2'b10, 2, 1, 16'h000F};
    vecs[4]  = '{2'b01, 16'hF0F0, 16'h0000, 4,  0, 2'b00, 2'b00, 0, 0, 16'h0F0F};
    vecs[5]  = '{2'b10, 16'h0000, 16'h8001, 0, 15, 2'b00, 2'b10, 0, 1, 16'hFFFF};
    vecs[6]  = '{2'b10, 16'h0000, 16'h8001, 0, 15, 2'b00, 2'b00, 0, 1, 16'h0001};
    vecs[7]  = '{2'b10, 16'h0000, 16'h0001, 0, 15, 2'b10, 2'b00, 0, 1, 16'h8000};
    vecs[8]  = '{2'b10, 16'h0000, 16'hA5A5, 0,  0, 2'b10, 2'b10, 0, 1, 16'hA5A5};
    vecs[9]  = '{2'b11, 16'h00FF, 16'h5555, 2,  3, 2'b00, 2'b00, 5, 0, 16'h003F};
    vecs[10] = '{2'b11, 16'h00FF, 16'h5555, 2,  3, 2'b00, 2'b00, 0, 1, 16'h0AAA};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].a0,
              vecs[i].a1, vecs[i].dir, vecs[i].arith, vecs[i].bp, vecs[i].exp_w,
              vecs[i].exp_d);
    end

    // reset while the shift is in flight
    req_valid = 2'b10; req_data1 = 16'h1234; req_amt1 = 4'd1; req_dir = 2'b00;
    req_arith = 2'b00; rsp_ready = 2'b00;
    @(posedge clk); #1;
    chk("rst_shift.pre_busy", 32'(busy), 32'd1);
    chk("rst_shift.pre_grant", 32'(grant_id), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_shift");
    release_and_serve_port1("rst_shift");

    // reset while the response is being offered
    req_valid = 2'b10; req_data1 = 16'h4321; req_amt1 = 4'd4; req_dir = 2'b10;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_resp.pre_rspv", 32'(rsp_valid), 32'd2);
    chk("rst_resp.pre_data", 32'(rsp_data), 32'h3210);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_resp");
    release_and_serve_port1("rst_resp");

    for (int t = 0; t < 60; t++) begin
      logic [1:0]  v, dir, arith;
      logic [15:0] d0, d1, exp_d;
      logic [3:0]  a0, a1;
      logic        w;
      int          gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        req_valid = 2'b00;
        @(negedge clk);
        chk($sformatf("rnd%0d.gap_ready", t), 32'(req_ready), 32'd0);
        chk($sformatf("rnd%0d.gap_busy", t), 32'(busy), 32'd0);
        @(posedge clk); #1;
      end
      v = 2'($urandom_range(1, 3));
      d0 = 16'($urandom); d1 = 16'($urandom);
      a0 = 4'($urandom); a1 = 4'($urandom);
      dir = 2'($urandom); arith = 2'($urandom);
      w = model_winner(v);
      exp_d = ref_shift(w ? d1 : d0, int'(w ? a1 : a0), dir[w], arith[w]);
      run_txn($sformatf("rnd%0d", t), v, d0, d1, a0, a1, dir, arith,
              $urandom_range(0, 3), w, exp_d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
